// File: rtl/fp_mul_arbiter.sv
// Round-robin arbiter/sequencer that time-shares one external combinational
// FP32 multiplier among NUM_REQ requesters. One operation is in flight at a
// time: grant (IDLE) -> operands on multiplier (ISSUE) -> response (RESP).
module fp_mul_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*32-1:0] req_a,
    input  logic [NUM_REQ*32-1:0] req_b,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [31:0]           mul_a,
    output logic [31:0]           mul_b,
    input  logic [31:0]           mul_c,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [31:0]           rsp_data,
    output logic                  rsp_nan,
    output logic                  rsp_inf,
    output logic                  busy
);

    typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

    state_e            state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]   grant_id_q, grant_id_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic [31:0]       mul_a_q, mul_a_d;
    logic [31:0]       mul_b_q, mul_b_d;
    logic [31:0]       rsp_data_q, rsp_data_d;
    logic              rsp_valid_q, rsp_valid_d;

    logic              gnt_found;
    logic [ID_W-1:0]   gnt_idx;
    logic [ID_W-1:0]   gnt_next;
    logic [NUM_REQ-1:0] gnt_oh;
    logic [31:0]       sel_a, sel_b;

    // Round-robin pick: lowest valid index at or above rr_ptr, else lowest valid overall.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (req_valid[j]) begin
                gnt_found = 1'b1;
                gnt_idx   = ID_W'(j);
            end
        end
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (req_valid[j] && (j >= int'(rr_ptr_q))) begin
                gnt_idx = ID_W'(j);
            end
        end
    end

    // Winner's operands, one-hot grant and the pointer value just past the winner.
    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        gnt_oh = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (ID_W'(j) == gnt_idx) begin
                sel_a     = req_a[32*j +: 32];
                sel_b     = req_b[32*j +: 32];
                gnt_oh[j] = gnt_found;
            end
        end
        if (int'(gnt_idx) == int'(NUM_REQ) - 1) begin
            gnt_next = '0;
        end else begin
            gnt_next = gnt_idx + 1'b1;
        end
    end

    // Sequencer next-state: grant in IDLE, capture product in ISSUE, hold in RESP.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_id_d  = grant_id_q;
        rsp_id_d    = rsp_id_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = rsp_valid_q;
        unique case (state_q)
            StIdle: begin
                if (gnt_found) begin
                    mul_a_d    = sel_a;
                    mul_b_d    = sel_b;
                    grant_id_d = gnt_idx;
                    rr_ptr_d   = gnt_next;
                    state_d    = StIssue;
                end
            end
            StIssue: begin
                rsp_data_d  = mul_c;
                rsp_id_d    = grant_id_q;
                rsp_valid_d = 1'b1;
                state_d     = StResp;
            end
            StResp: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers; reset drops any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            rr_ptr_q    <= '0;
            grant_id_q  <= '0;
            rsp_id_q    <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_id_q  <= grant_id_d;
            rsp_id_q    <= rsp_id_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    // Outputs; grant is gated by rst_n so nothing is accepted while in reset.
    always_comb begin
        req_ready = (rst_n && (state_q == StIdle)) ? gnt_oh : '0;
        mul_a     = mul_a_q;
        mul_b     = mul_b_q;
        rsp_valid = rsp_valid_q;
        rsp_id    = rsp_id_q;
        rsp_data  = rsp_data_q;
        rsp_nan   = (&rsp_data_q[30:23]) && (|rsp_data_q[22:0]);
        rsp_inf   = (&rsp_data_q[30:23]) && !(|rsp_data_q[22:0]);
        busy      = (state_q != StIdle);
    end

endmodule
